// File: rtl/lc_tx_seq_pkg.sv
// Shared types for the life cycle enable sequencer: lc_tx_t encodings, FSM states, ack validity helper.
// LC_TX_SEQ_SPARSE_FSM_EN selects a 6-bit Hamming-distance-3 state encoding instead of dense binary.
package lc_tx_seq_pkg;

  localparam int unsigned TxWidth = 4;

  typedef logic [TxWidth-1:0] lc_tx_t;

  localparam lc_tx_t On  = 4'b1010;
  localparam lc_tx_t Off = 4'b0101;

`ifdef LC_TX_SEQ_SPARSE_FSM_EN
  typedef enum logic [5:0] {
    StOff     = 6'b000000,
    StWaitOn  = 6'b000111,
    StOn      = 6'b111000,
    StWaitOff = 6'b011011,
    StError   = 6'b101101
  } state_e;
`else
  typedef enum logic [2:0] {
    StOff     = 3'd0,
    StWaitOn  = 3'd1,
    StOn      = 3'd2,
    StWaitOff = 3'd3,
    StError   = 3'd4
  } state_e;
`endif

  function automatic logic lc_tx_valid(lc_tx_t val);
    return (val == On) || (val == Off);
  endfunction

endpackage

// File: rtl/lc_tx_ack_check.sv
// Reduces NumRx lc_tx_t acknowledgments to all-On / all-Off / any-invalid flags.
module lc_tx_ack_check
  import lc_tx_seq_pkg::*;
#(
  parameter int unsigned NumRx = 2
) (
  input  lc_tx_t [NumRx-1:0] ack_i,
  output logic               all_on_o,
  output logic               all_off_o,
  output logic               any_invalid_o
);

  always_comb begin
    all_on_o      = 1'b1;
    all_off_o     = 1'b1;
    any_invalid_o = 1'b0;
    for (int unsigned i = 0; i < NumRx; i++) begin
      all_on_o      = all_on_o & (ack_i[i] == On);
      all_off_o     = all_off_o & (ack_i[i] == Off);
      any_invalid_o = any_invalid_o | ~lc_tx_valid(ack_i[i]);
    end
  end

endmodule

// File: rtl/lc_tx_seq_ctrl.sv
// Sequences an lc_tx_t enable toward NumRx receivers with dwell, ack wait, timeout and sticky error.
// Build option: LC_TX_SEQ_SPARSE_FSM_EN (sparse state encoding, see lc_tx_seq_pkg).
module lc_tx_seq_ctrl
  import lc_tx_seq_pkg::*;
#(
  parameter int unsigned NumRx         = 2,
  parameter int unsigned MinHoldCycles = 4,
  parameter int unsigned AckTimeout    = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_en_i,
  input  lc_tx_t [NumRx-1:0] ack_i,
  output lc_tx_t             lc_en_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  localparam int unsigned CntMax   = (MinHoldCycles > AckTimeout) ? MinHoldCycles : AckTimeout;
  localparam int unsigned CntWidth = $clog2(CntMax + 1);

  typedef logic [CntWidth-1:0] cnt_t;

  localparam cnt_t DwellMax = cnt_t'(MinHoldCycles);
  localparam cnt_t TmoLast  = cnt_t'(AckTimeout - 1);

  state_e state_q, state_d;
  cnt_t   dwell_q, dwell_d;
  cnt_t   tmo_q, tmo_d;
  logic   inv_q, inv_d;
  logic   done_q, done_d;
  lc_tx_t lc_en_q, lc_en_d;

  logic all_on, all_off, any_invalid;

  lc_tx_ack_check #(
    .NumRx(NumRx)
  ) u_ack_check (
    .ack_i         (ack_i),
    .all_on_o      (all_on),
    .all_off_o     (all_off),
    .any_invalid_o (any_invalid)
  );

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    tmo_d   = tmo_q;
    inv_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      StOff: begin
        if (dwell_q != DwellMax) dwell_d = dwell_q + cnt_t'(1);
        if (req_en_i && (dwell_q == DwellMax)) begin
          state_d = StWaitOn;
          dwell_d = '0;
          tmo_d   = '0;
        end
      end
      StWaitOn: begin
        tmo_d   = tmo_q + cnt_t'(1);
        inv_d   = any_invalid;
        dwell_d = '0;
        // completion takes priority over both error causes
        if (all_on) begin
          state_d = StOn;
          done_d  = 1'b1;
        end else if ((any_invalid && inv_q) || (tmo_q == TmoLast)) begin
          state_d = StError;
        end
      end
      StOn: begin
        if (dwell_q != DwellMax) dwell_d = dwell_q + cnt_t'(1);
        if (!req_en_i && (dwell_q == DwellMax)) begin
          state_d = StWaitOff;
          dwell_d = '0;
          tmo_d   = '0;
        end
      end
      StWaitOff: begin
        tmo_d   = tmo_q + cnt_t'(1);
        inv_d   = any_invalid;
        dwell_d = '0;
        if (all_off) begin
          state_d = StOff;
          done_d  = 1'b1;
        end else if ((any_invalid && inv_q) || (tmo_q == TmoLast)) begin
          state_d = StError;
        end
      end
      StError: begin
        state_d = StError;
      end
      default: begin
        state_d = StError;
      end
    endcase
    // output flop is loaded from the next state so lc_en_o tracks state_q without extra latency
    lc_en_d = ((state_d == StWaitOn) || (state_d == StOn)) ? On : Off;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StOff;
      dwell_q <= '0;
      tmo_q   <= '0;
      inv_q   <= 1'b0;
      done_q  <= 1'b0;
      lc_en_q <= Off;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      tmo_q   <= tmo_d;
      inv_q   <= inv_d;
      done_q  <= done_d;
      lc_en_q <= lc_en_d;
    end
  end

  assign lc_en_o = lc_en_q;
  assign busy_o  = (state_q == StWaitOn) || (state_q == StWaitOff);
  assign done_o  = done_q;
  assign err_o   = (state_q == StError);

endmodule

// File: tb/tb_lc_tx_seq_ctrl.sv
// Self-checking bench for lc_tx_seq_ctrl: vector table, directed corner sequences, randomized run vs phase model.
module tb_lc_tx_seq_ctrl;
  import lc_tx_seq_pkg::*;

  localparam int MinHold = 4;
  localparam int AckTmo  = 64;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             req_en_i = 1'b0;
  lc_tx_t [1:0]     ack_i;
  lc_tx_t           lc_en_o;
  logic             busy_o, done_o, err_o;

  lc_tx_seq_ctrl #(
    .NumRx         (2),
    .MinHoldCycles (MinHold),
    .AckTimeout    (AckTmo)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .req_en_i (req_en_i),
    .ack_i    (ack_i),
    .lc_en_o  (lc_en_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .err_o    (err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: phase plus age-in-phase and run length of invalid acks
  localparam int P_OFF = 0, P_WON = 1, P_ON = 2, P_WOFF = 3, P_ERR = 4;
  int   m_ph, m_age, m_inv;
  logic m_done;

  function automatic lc_tx_t m_en();
    return (m_ph == P_WON || m_ph == P_ON) ? On : Off;
  endfunction

  task automatic model_reset();
    m_ph = P_OFF; m_age = 0; m_inv = 0; m_done = 1'b0;
  endtask

  task automatic model_tick(input logic r, input lc_tx_t a0, input lc_tx_t a1);
    bit aon, aoff, bad, want, arrived;
    aon  = (a0 == On) && (a1 == On);
    aoff = (a0 == Off) && (a1 == Off);
    bad  = !(a0 == On || a0 == Off) || !(a1 == On || a1 == Off);
    m_done = 1'b0;
    if (m_ph == P_OFF || m_ph == P_ON) begin
      want = (m_ph == P_OFF) ? r : !r;
      if (want && m_age >= MinHold) begin
        m_ph = m_ph + 1; m_age = 0; m_inv = 0;
      end else m_age++;
    end else if (m_ph == P_WON || m_ph == P_WOFF) begin
      arrived = (m_ph == P_WON) ? aon : aoff;
      if (arrived) begin
        m_ph = (m_ph + 1) % 4; m_age = 0; m_done = 1'b1;
      end else begin
        m_inv = bad ? m_inv + 1 : 0;
        if (m_inv >= 2 || m_age >= AckTmo - 1) m_ph = P_ERR;
        else m_age++;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_model(input string name);
    check(name, {25'd0, lc_en_o, busy_o, done_o, err_o},
          {25'd0, m_en(), logic'(m_ph == P_WON || m_ph == P_WOFF), m_done, logic'(m_ph == P_ERR)});
  endtask

  // Inputs are applied at the falling edge, outputs compared at the next falling edge
  task automatic drive(input logic r, input lc_tx_t a0, input lc_tx_t a1);
    req_en_i = r; ack_i[0] = a0; ack_i[1] = a1;
    model_tick(r, a0, a1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step(input string name, input logic r, input lc_tx_t a0, input lc_tx_t a1);
    drive(r, a0, a1);
    check_model(name);
  endtask

  task automatic do_reset();
    rst_i = 1'b1; req_en_i = 1'b0; ack_i[0] = Off; ack_i[1] = Off;
    repeat (2) @(negedge clk);
    model_reset();
    check("reset_state", {25'd0, lc_en_o, busy_o, done_o, err_o}, {25'd0, Off, 3'b000});
    rst_i = 1'b0;
  endtask

  task automatic goto_wait_on();
    int k;
    k = 0;
    while (!busy_o && k < 20) begin
      step("enter_wait_on", 1'b1, Off, Off);
      k++;
    end
    check("wait_on_reached", {31'd0, busy_o}, 32'd1);
  endtask

  typedef struct {
    logic   req;
    lc_tx_t a0, a1;
    lc_tx_t en;
    logic   busy, done, err;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic req, input lc_tx_t a0, input lc_tx_t a1,
                     input lc_tx_t en, input logic busy, input logic done, input logic err);
    vec_t v;
    v.req = req; v.a0 = a0; v.a1 = a1; v.en = en; v.busy = busy; v.done = done; v.err = err;
    vq.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int     k;
    int     stuck;
    logic   r;
    lc_tx_t a [2];

    ack_i[0] = Off; ack_i[1] = Off;

    // Off dwell, enable, ack, On dwell, disable, ack, re-enable with a single transient invalid ack
    for (int i = 0; i < 4; i++) add(1'b1, Off, Off, Off, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) add(1'b1, Off, Off, On, 1'b1, 1'b0, 1'b0);
    add(1'b1, On, On, On, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) add(1'b0, On, On, On, 1'b0, 1'b0, 1'b0);
    add(1'b0, On, On, Off, 1'b1, 1'b0, 1'b0);
    add(1'b0, Off, Off, Off, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) add(1'b0, Off, Off, Off, 1'b0, 1'b0, 1'b0);
    add(1'b1, Off, Off, On, 1'b1, 1'b0, 1'b0);
    add(1'b1, On, 4'b1110, On, 1'b1, 1'b0, 1'b0);
    add(1'b1, On, On, On, 1'b0, 1'b1, 1'b0);

    do_reset();
    foreach (vq[i]) begin
      drive(vq[i].req, vq[i].a0, vq[i].a1);
      check($sformatf("vec%0d", i), {25'd0, lc_en_o, busy_o, done_o, err_o},
            {25'd0, vq[i].en, vq[i].busy, vq[i].done, vq[i].err});
    end

    // Invalid ack held two cycles in WaitOn
    do_reset();
    goto_wait_on();
    step("inv_first", 1'b1, On, 4'b1110);
    check("inv_one_tolerated", {31'd0, err_o}, 32'd0);
    step("inv_second", 1'b1, On, 4'b1110);
    check("inv_two_err", {28'd0, lc_en_o, err_o}, {28'd0, Off, 1'b1});

    // Ack timeout with one receiver stuck at Off, then sticky error
    do_reset();
    goto_wait_on();
    k = 0;
    while (!err_o && k < 100) begin
      step("timeout_wait", 1'b1, On, Off);
      k++;
    end
    check("timeout_cycles", k, AckTmo);
    for (int i = 0; i < 6; i++) begin
      step("err_sticky", logic'(i % 2), Off, Off);
      check("err_sticky_out", {28'd0, lc_en_o, err_o}, {28'd0, Off, 1'b1});
    end

    // Asynchronous reset mid-transition
    do_reset();
    goto_wait_on();
    #2 rst_i = 1'b1;
    #1 check("async_rst", {25'd0, lc_en_o, busy_o, done_o, err_o}, {25'd0, Off, 3'b000});
    @(negedge clk);
    model_reset();
    rst_i = 1'b0;
    k = 0;
    while (!busy_o && k < 20) begin
      step("reenable", 1'b1, Off, Off);
      k++;
    end
    check("reenable_cycles", k, MinHold + 1);

`ifdef LC_TX_SEQ_SPARSE_FSM_EN
    // Illegal state code escalates to error on the next edge
    do_reset();
    goto_wait_on();
    step("to_on", 1'b1, On, On);
    force dut.state_q = lc_tx_seq_pkg::state_e'(6'b110011);
    #1 release dut.state_q;
    @(posedge clk);
    @(negedge clk);
    check("illegal_state", {28'd0, lc_en_o, err_o}, {28'd0, Off, 1'b1});
`endif

    // Randomized episodes: receivers mostly echo, sometimes lag, glitch or stick at Off
    for (int ep = 0; ep < 20; ep++) begin
      do_reset();
      r = logic'($urandom_range(0, 1));
      stuck = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : -1;
      a[0] = Off; a[1] = Off;
      for (int c = 0; c < 200; c++) begin
        if ($urandom_range(0, 15) == 0) r = ~r;
        for (int i = 0; i < 2; i++) begin
          k = int'($urandom_range(0, 39));
          if (k == 0) a[i] = lc_tx_t'($urandom);
          else if (k > 13) a[i] = m_en();
          if (i == stuck) a[i] = Off;
        end
        step("random", r, a[0], a[1]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
